id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage sitting directly upstream of the ALU.
- Registers decoded operands and control from the decode stage each cycle.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and by a one-cycle load-use stall with bubble insertion.
- Drives the ALU operand and opcode inputs; alu_op uses ALU encoding (000 zero, 001 add, 010 sub, 011 and, 100 or, 101 slt-style B>A).

Parameters:
- XLEN, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode stage presents a valid instruction
- in_rs  in  RW  source register 1 index
- in_rt  in  RW  source register 2 index
- in_rd  in  RW  destination register index
- in_rs_val  in  XLEN  register-file value of rs
- in_rt_val  in  XLEN  register-file value of rt
- in_imm  in  XLEN  sign-extended immediate
- in_alu_src  in  1  1: B operand = immediate
- in_alu_op  in  3  ALU opcode
- in_mem_read  in  1  instruction is a load
- in_mem_write  in  1  instruction is a store
- in_reg_write  in  1  instruction writes rd
- flush  in  1  squash contents (branch taken)
- exmem_reg_write  in  1  EX/MEM writes back
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  XLEN  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes back
- memwb_rd  in  RW  MEM/WB destination
- memwb_data  in  XLEN  MEM/WB writeback data
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_op  out  3  ALU opcode
- out_valid  out  1  stage holds a real instruction
- out_rd  out  RW  destination index
- out_reg_write  out  1  gated by out_valid
- out_mem_read  out  1  gated by out_valid
- out_mem_write  out  1  gated by out_valid
- out_store_data  out  XLEN  forwarded rt value for stores

Behaviour:
- Reset: all registered fields cleared; out_valid=0, alu_op=000, out_rd=0, all control outputs 0. alu_a/alu_b are forwarded from the cleared registers, so they read 0 when no forwarding condition matches.
- Latency: one cycle from decode inputs to registered outputs.
- Load-use hazard, combinational:
  - stall=1 when out_valid & out_mem_read & out_rd!=0 & in_valid & (out_rd==in_rs | (out_rd==in_rt & (!in_alu_src | in_mem_write))).
- Register update on clock, in priority order:
  - rst: clear.
  - flush: clear, bubble inserted.
  - stall: load bubble (out_valid=0, all controls 0, alu_op=000); upstream holds the instruction, so it re-presents next cycle.
  - Otherwise: capture inputs; out_valid=in_valid; controls are zeroed when in_valid=0.
- Simultaneous flush and stall: flush wins; stall output is still driven combinationally. Upstream discards the held instruction because of the flush.
- Forwarding, combinational, per operand (rs path shown, rt path identical):
  - Priority 1: exmem_reg_write & exmem_rd!=0 & exmem_rd==reg_rs gives exmem_result.
  - Priority 2: memwb_reg_write & memwb_rd!=0 & memwb_rd==reg_rs gives memwb_data.
  - Otherwise the registered value.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_a = forwarded rs.
  - alu_b = reg_alu_src ? reg_imm : forwarded rt.
  - out_store_data = forwarded rt in all cases.
- No arithmetic performed; widths pass through unchanged.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined:
  - Adds outputs bubble_cnt (32) and instr_cnt (32), both cleared on rst.
  - bubble_cnt increments on each clock where stall or flush loads a bubble.
  - instr_cnt increments on each clock where a valid instruction is captured.
  - Both counters wrap at 2^32-1 → 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles with random inputs → out_valid=0, alu_op=000, alu_a=alu_b=0, stall=0.
- Capture add, rs_val=5, rt_val=7, alu_src=0 → next cycle alu_a=5, alu_b=7, alu_op=001, out_valid=1.
- Forwarding priority: registered rs=3; exmem_rd=3 with result 0x11; memwb_rd=3 with data 0x22; both write → alu_a=0x11. Drop exmem_reg_write → alu_a=0x22. Set rd=0 on both paths → registered value.
- Load-use: stage holds lw rd=4; decode presents add rs=4 → stall=1 that cycle, next cycle out_valid=0. Re-presented add is captured the following cycle with stall=0.
- Flush while a valid sub is presented → next cycle out_valid=0, out_reg_write=0. With flush=1 and stall=1 together → bubble, no capture.
- ID_EX_PERF_CNT_EN: 3 captures, 1 stall, 1 flush → instr_cnt=3, bubble_cnt=2. Preload near 2^32-1 → wraps to 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register in front of the ALU.
// Captures decoded operands/control, forwards from EX/MEM and MEM/WB,
// and detects load-use hazards. A detected hazard stalls upstream and
// inserts a bubble here.
// Optional build macro ID_EX_PERF_CNT_EN adds the bubble_cnt/instr_cnt
// performance counters.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [RW-1:0]   in_rs,
  input  logic [RW-1:0]   in_rt,
  input  logic [RW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_rs_val,
  input  logic [XLEN-1:0] in_rt_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alu_src,
  input  logic [2:0]      in_alu_op,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [RW-1:0]   exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RW-1:0]   memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic            stall,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic            out_valid,
  output logic [RW-1:0]   out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [XLEN-1:0] out_store_data
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     instr_cnt
`endif
);

  // Forwarding mux for one operand. The newer EX/MEM result beats
  // MEM/WB, and register 0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RW-1:0]   idx,
    input logic [XLEN-1:0] reg_val,
    input logic            ex_we,
    input logic [RW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_val,
    input logic            wb_we,
    input logic [RW-1:0]   wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    logic [XLEN-1:0] res;
    if (ex_we && (ex_rd != {RW{1'b0}}) && (ex_rd == idx)) begin
      res = ex_val;
    end else if (wb_we && (wb_rd != {RW{1'b0}}) && (wb_rd == idx)) begin
      res = wb_val;
    end else begin
      res = reg_val;
    end
    return res;
  endfunction

  logic            valid_r;
  logic [RW-1:0]   rs_r;
  logic [RW-1:0]   rt_r;
  logic [RW-1:0]   rd_r;
  logic [XLEN-1:0] rs_val_r;
  logic [XLEN-1:0] rt_val_r;
  logic [XLEN-1:0] imm_r;
  logic            alu_src_r;
  logic [2:0]      alu_op_r;
  logic            mem_read_r;
  logic            mem_write_r;
  logic            reg_write_r;

  logic            stall_s;
  logic [XLEN-1:0] fwd_rs_s;
  logic [XLEN-1:0] fwd_rt_s;

  // Load-use hazard: a load here whose rd feeds the presented instruction.
  // rt only counts when it is actually read as a register (B operand or store data).
  always_comb begin
    stall_s = 1'b0;
    if (valid_r && mem_read_r && (rd_r != {RW{1'b0}}) && in_valid) begin
      stall_s = (rd_r == in_rs) ||
                ((rd_r == in_rt) && (!in_alu_src || in_mem_write));
    end else begin
      stall_s = 1'b0;
    end
  end

  // Pipeline register. Priority: reset, flush, load-use bubble, capture.
  always_ff @(posedge clk) begin
    if (rst || flush || stall_s) begin
      valid_r     <= 1'b0;
      rs_r        <= {RW{1'b0}};
      rt_r        <= {RW{1'b0}};
      rd_r        <= {RW{1'b0}};
      rs_val_r    <= {XLEN{1'b0}};
      rt_val_r    <= {XLEN{1'b0}};
      imm_r       <= {XLEN{1'b0}};
      alu_src_r   <= 1'b0;
      alu_op_r    <= 3'b000;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      reg_write_r <= 1'b0;
    end else begin
      valid_r     <= in_valid;
      rs_r        <= in_rs;
      rt_r        <= in_rt;
      rd_r        <= in_rd;
      rs_val_r    <= in_rs_val;
      rt_val_r    <= in_rt_val;
      imm_r       <= in_imm;
      alu_src_r   <= in_alu_src & in_valid;
      alu_op_r    <= in_valid ? in_alu_op : 3'b000;
      mem_read_r  <= in_mem_read & in_valid;
      mem_write_r <= in_mem_write & in_valid;
      reg_write_r <= in_reg_write & in_valid;
    end
  end

  // Operand forwarding and B-operand selection.
  always_comb begin
    fwd_rs_s = fwd_sel(rs_r, rs_val_r, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
    fwd_rt_s = fwd_sel(rt_r, rt_val_r, exmem_reg_write, exmem_rd, exmem_result,
                       memwb_reg_write, memwb_rd, memwb_data);
    if (alu_src_r) begin
      alu_b = imm_r;
    end else begin
      alu_b = fwd_rt_s;
    end
  end

  assign stall          = stall_s;
  assign alu_a          = fwd_rs_s;
  assign out_store_data = fwd_rt_s;
  assign alu_op         = alu_op_r;
  assign out_valid      = valid_r;
  assign out_rd         = rd_r;
  assign out_reg_write  = reg_write_r & valid_r;
  assign out_mem_read   = mem_read_r & valid_r;
  assign out_mem_write  = mem_write_r & valid_r;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] instr_cnt_r;

  // Performance counters. Both wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_r <= 32'd0;
      instr_cnt_r  <= 32'd0;
    end else if (flush || stall_s) begin
      bubble_cnt_r <= bubble_cnt_r + 32'd1;
      instr_cnt_r  <= instr_cnt_r;
    end else if (in_valid) begin
      bubble_cnt_r <= bubble_cnt_r;
      instr_cnt_r  <= instr_cnt_r + 32'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
      instr_cnt_r  <= instr_cnt_r;
    end
  end

  assign bubble_cnt = bubble_cnt_r;
  assign instr_cnt  = instr_cnt_r;
`endif

endmodule
